styler_shifter: RTL and testbench
=================================

Name: styler_shifter

Overview:
- Pixel serializer directly downstream of the styler: accepts one styled 16-pixel scanline word (styler bitmapOut) per valid/ready handshake.
- Shifts the word out one pixel per pixel-enable, bit 15 first (bit 15 = leftmost pixel).
- Double-buffered (hold register plus shift register), so the upstream fetch/style pipeline has one full character time of slack.
- Flags underflow when the display demands a pixel and no word is loaded.

Parameters:
- WIDTH, 16, bits per word; must match styler bitmap width.
- CW, 4, bit-counter width; CW = log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bitmapIn  input  WIDTH  styled scanline word from styler.
- bitmapValid  input  1  bitmapIn is valid this cycle.
- bitmapReady  output  1  the block accepts bitmapIn this cycle.
- pixelEnable  input  1  display consumes one pixel this cycle.
- lineStart  input  1  synchronous flush at start of line/blank.
- pixelOut  output  1  current pixel value.
- pixelValid  output  1  pixelOut comes from a loaded word.
- wordDone  output  1  one-cycle pulse: last pixel of a word was consumed.
- underflow  output  1  one-cycle pulse: pixelEnable arrived while the shifter was empty.

Behaviour:
- State:
  - holdReg[WIDTH] with holdFull.
  - shiftReg[WIDTH] with shiftFull.
  - bitCnt[CW].
- Reset (async, rst=1): every register clears to 0. Outputs during and immediately after reset: bitmapReady=1, pixelOut=0, pixelValid=0, wordDone=0, underflow=0.
- Combinational outputs, all driven from registers only:
  - bitmapReady = ~holdFull. There is no combinational path from pixelEnable or bitmapValid.
  - pixelOut = shiftFull & shiftReg[WIDTH-1].
  - pixelValid = shiftFull.
- Accept: bitmapValid & bitmapReady at an edge gives holdReg <= bitmapIn and holdFull <= 1. An offered word is never dropped; the source holds it until ready.
- Consume: pixelEnable & shiftFull at an edge shifts shiftReg left by one (0 enters at LSB) and increments bitCnt.
  - lastPix = pixelEnable & shiftFull & (bitCnt == WIDTH-1).
  - On lastPix, shiftFull <= 0 and bitCnt <= 0, unless a reload happens at the same edge.
- Reload: at an edge where holdFull & (~shiftFull | lastPix):
  - shiftReg <= holdReg, shiftFull <= 1, bitCnt <= 0, holdFull <= 0.
  - If an accept happens at the same edge, the new word goes into hold and holdFull stays 1.
- Latency: accept at edge N, hold full after N; reload at edge N+1; first pixel visible on pixelOut in the cycle after N+1, which is 2 cycles from accept.
- Back-to-back words with both registers full: gapless output, no idle pixel between word k bit 0 and word k+1 bit 15.
- wordDone: registered; equals lastPix delayed by 1 cycle.
- underflow: registered; equals (pixelEnable & ~shiftFull & ~lineStart) delayed by 1 cycle. The display shows pixelOut=0 (background) for that pixel. The block takes no other action.
- lineStart (synchronous, highest priority):
  - Clears holdFull, shiftFull and bitCnt.
  - Any accept, consume, reload or underflow in the same cycle is discarded.
  - bitmapReady is 1 from the next cycle.
- Simultaneous accept + reload + consume at one edge is legal and required to work.
- rst asserted mid-word: state is lost immediately; pending words are not replayed.

Decomposition:
- Shared package styler_pkg holds:
  - STYLER_WIDTH = 16.
  - STYLER_CW = 4.
  - typedef styler_bitmap_t (logic [15:0]).
  - The styler, the fetch unit and this block all use it.
- Natural sub-module: styler_shifter_hold, a one-entry valid/ready skid register (holdReg/holdFull). It is reusable by the fetch unit.
- Shift register and counter stay in the top module.

Test Plan:
- After reset, bitmapValid=1, bitmapIn=16'hA5C3, pixelEnable held 1 from cycle 2 -> pixelOut sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. wordDone pulses 1 cycle after the 16th pixel. No underflow.
- Three words 16'hFFFF, 16'h0000, 16'h8001 streamed with continuous pixelEnable -> 48 gapless pixels: 16 ones, then 16 zeros, then 1, fourteen 0s, 1. bitmapReady drops only while hold is full.
- pixelEnable=1 with no word loaded for 3 cycles -> pixelOut=0, pixelValid=0, three underflow pulses. Then load 16'h8000 -> first pixel 1, underflow stops.
- lineStart asserted after 5 pixels of 16'hFFFF, with 16'h1234 also in hold -> next cycle pixelValid=0 and bitmapReady=1. Both words are discarded; the next accepted word starts at bit 15.
- Async rst pulsed mid-word, between clock edges -> outputs go to reset values immediately without waiting for an edge. The post-reset word shifts correctly.
- Random valid/pixelEnable toggling for 10k cycles against a reference model -> output pixel stream equals the concatenation of accepted words (MSB first). No loss or duplication; underflow count matches the model.

Source files
------------

// File: rtl/styler_pkg.sv
// Shared styler types: bitmap word width and the bit-counter width derived from it.
package styler_pkg;

    localparam int STYLER_WIDTH = 16;
    localparam int STYLER_CW    = 4;

    typedef logic [STYLER_WIDTH-1:0] styler_bitmap_t;

endpackage

// File: rtl/styler_shifter_hold.sv
// One-entry valid/ready holding register; ready = empty, so no comb path from the consumer.
// Latency: word visible on out_dat_o the cycle after accept; flush_i empties it synchronously.
module styler_shifter_hold
    import styler_pkg::*;
#(
    parameter int WIDTH = STYLER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_dat_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_dat_o,
    output logic             out_vld_o,
    input  logic             out_pop_i
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             full_q, full_d;
    logic             accept;

    assign accept    = in_vld_i & ~full_q;
    assign in_rdy_o  = ~full_q;
    assign out_dat_o = dat_q;
    assign out_vld_o = full_q;

    always_comb begin
        dat_d  = dat_q;
        full_d = full_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            // A pop at the same edge still leaves the entry full with the new word.
            dat_d  = in_dat_i;
            full_d = 1'b1;
        end else if (out_pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q  <= '0;
            full_q <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/styler_shifter.sv
// Pixel serializer: hold + shift double buffer, MSB first, one pixel per pixelEnable.
// Accept-to-first-pixel is 2 cycles; bitmapReady depends only on hold occupancy.
module styler_shifter
    import styler_pkg::*;
#(
    parameter int WIDTH = STYLER_WIDTH,
    parameter int CW    = STYLER_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bitmapIn,
    input  logic             bitmapValid,
    output logic             bitmapReady,
    input  logic             pixelEnable,
    input  logic             lineStart,
    output logic             pixelOut,
    output logic             pixelValid,
    output logic             wordDone,
    output logic             underflow
);

    logic [WIDTH-1:0] hold_dat;
    logic             hold_full;
    logic             consume, last_pix, reload;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic             shift_full_q, shift_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             word_done_q, word_done_d;
    logic             underflow_q, underflow_d;

    styler_shifter_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (lineStart),
        .in_dat_i  (bitmapIn),
        .in_vld_i  (bitmapValid),
        .in_rdy_o  (bitmapReady),
        .out_dat_o (hold_dat),
        .out_vld_o (hold_full),
        .out_pop_i (reload)
    );

    assign consume  = pixelEnable & shift_full_q;
    assign last_pix = consume & (bit_cnt_q == CW'(WIDTH-1));
    // Reloading on the last pixel keeps back-to-back words gapless.
    assign reload   = hold_full & (~shift_full_q | last_pix);

    always_comb begin
        shift_d      = shift_q;
        shift_full_d = shift_full_q;
        bit_cnt_d    = bit_cnt_q;
        word_done_d  = last_pix & ~lineStart;
        underflow_d  = pixelEnable & ~shift_full_q & ~lineStart;
        if (lineStart) begin
            shift_full_d = 1'b0;
            bit_cnt_d    = '0;
        end else if (reload) begin
            shift_d      = hold_dat;
            shift_full_d = 1'b1;
            bit_cnt_d    = '0;
        end else if (consume) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (last_pix) begin
                shift_full_d = 1'b0;
                bit_cnt_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            shift_full_q <= 1'b0;
            bit_cnt_q    <= '0;
            word_done_q  <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            shift_full_q <= shift_full_d;
            bit_cnt_q    <= bit_cnt_d;
            word_done_q  <= word_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pixelOut   = shift_full_q & shift_q[WIDTH-1];
    assign pixelValid = shift_full_q;
    assign wordDone   = word_done_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_styler_shifter.sv
// Directed and randomized checks of the styler pixel serializer.
module tb_styler_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bitmapIn;
    logic        bitmapValid;
    logic        bitmapReady;
    logic        pixelEnable;
    logic        lineStart;
    logic        pixelOut;
    logic        pixelValid;
    logic        wordDone;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    styler_shifter dut (
        .clk         (clk),
        .rst         (rst),
        .bitmapIn    (bitmapIn),
        .bitmapValid (bitmapValid),
        .bitmapReady (bitmapReady),
        .pixelEnable (pixelEnable),
        .lineStart   (lineStart),
        .pixelOut    (pixelOut),
        .pixelValid  (pixelValid),
        .wordDone    (wordDone),
        .underflow   (underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_line();
        lineStart   = 1'b1;
        pixelEnable = 1'b0;
        bitmapValid = 1'b0;
        step();
        lineStart   = 1'b0;
    endtask

    // {bitmapReady, pixelOut, pixelValid, wordDone, underflow}
    task automatic test_reset();
        rst         = 1'b1;
        bitmapIn    = '0;
        bitmapValid = 1'b0;
        pixelEnable = 1'b0;
        lineStart   = 1'b0;
        #2;
        checks++;
        if ({bitmapReady, pixelOut, pixelValid, wordDone, underflow} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_during got %b exp 10000",
                     {bitmapReady, pixelOut, pixelValid, wordDone, underflow});
        end
        #10;
        rst = 1'b0;
        step();
        checks++;
        if ({bitmapReady, pixelOut, pixelValid, wordDone, underflow} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_after got %b exp 10000",
                     {bitmapReady, pixelOut, pixelValid, wordDone, underflow});
        end
    endtask

    task automatic test_single_word();
        logic [15:0] exp_seq;
        exp_seq     = 16'b1010_0101_1100_0011;
        bitmapIn    = 16'hA5C3;
        bitmapValid = 1'b1;
        checks++;
        if (bitmapReady !== 1'b1) begin
            errors++;
            $display("FAIL single_ready0 got %b exp 1", bitmapReady);
        end
        step();
        bitmapValid = 1'b0;
        checks++;
        if ({bitmapReady, pixelValid} !== 2'b00) begin
            errors++;
            $display("FAIL single_held got rdy/pv %b exp 00", {bitmapReady, pixelValid});
        end
        step();
        checks++;
        if (pixelValid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got pv %b exp 1", pixelValid);
        end
        pixelEnable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({pixelOut, wordDone, underflow} !== {exp_seq[15-i], 2'b00}) begin
                errors++;
                $display("FAIL single_pix%0d got po/wd/uf %b exp %b", i,
                         {pixelOut, wordDone, underflow}, {exp_seq[15-i], 2'b00});
            end
            step();
        end
        pixelEnable = 1'b0;
        checks++;
        if ({wordDone, pixelValid, underflow} !== 3'b100) begin
            errors++;
            $display("FAIL single_done got wd/pv/uf %b exp 100", {wordDone, pixelValid, underflow});
        end
        step();
        checks++;
        if (wordDone !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse got %b exp 0", wordDone);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [47:0] exp_bits;
        int          idx;
        int          got;
        bit          started;
        bit          accepted;
        words[0] = 16'hFFFF;
        words[1] = 16'h0000;
        words[2] = 16'h8001;
        exp_bits = 48'hFFFF_0000_8001;
        idx      = 0;
        got      = 0;
        started  = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            bitmapValid = (idx < 3);
            bitmapIn    = (idx < 3) ? words[idx] : 16'h0;
            if (pixelValid) started = 1'b1;
            pixelEnable = started && (got < 48);
            if (pixelEnable) begin
                checks++;
                if ({pixelValid, pixelOut, underflow} !== {1'b1, exp_bits[47-got], 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_pix%0d got pv/po/uf %b exp %b", got,
                             {pixelValid, pixelOut, underflow}, {1'b1, exp_bits[47-got], 1'b0});
                end
                got++;
            end
            accepted = bitmapValid & bitmapReady;
            step();
            if (accepted) idx++;
        end
        pixelEnable = 1'b0;
        bitmapValid = 1'b0;
        checks++;
        if (got != 48 || idx != 3 || pixelValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got pixels %0d words %0d pv %b exp 48 3 0", got, idx, pixelValid);
        end
    endtask

    task automatic test_underflow();
        pixelEnable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({underflow, pixelValid, pixelOut} !== 3'b100) begin
                errors++;
                $display("FAIL uflow_%0d got uf/pv/po %b exp 100", k, {underflow, pixelValid, pixelOut});
            end
        end
        pixelEnable = 1'b0;
        bitmapValid = 1'b1;
        bitmapIn    = 16'h8000;
        step();
        bitmapValid = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uflow_stop got %b exp 0", underflow);
        end
        step();
        checks++;
        if ({pixelValid, pixelOut, underflow} !== 3'b110) begin
            errors++;
            $display("FAIL uflow_first got pv/po/uf %b exp 110", {pixelValid, pixelOut, underflow});
        end
        pixelEnable = 1'b1;
        step();
        checks++;
        if ({pixelValid, pixelOut, underflow} !== 3'b100) begin
            errors++;
            $display("FAIL uflow_second got pv/po/uf %b exp 100", {pixelValid, pixelOut, underflow});
        end
        flush_line();
    endtask

    task automatic test_line_start();
        bitmapIn    = 16'hFFFF;
        bitmapValid = 1'b1;
        step();
        bitmapIn = 16'h1234;
        step();
        checks++;
        if ({pixelValid, bitmapReady} !== 2'b11) begin
            errors++;
            $display("FAIL ls_loaded got pv/rdy %b exp 11", {pixelValid, bitmapReady});
        end
        pixelEnable = 1'b1;
        step();
        bitmapValid = 1'b0;
        checks++;
        if ({bitmapReady, pixelOut} !== 2'b01) begin
            errors++;
            $display("FAIL ls_hold_full got rdy/po %b exp 01", {bitmapReady, pixelOut});
        end
        repeat (4) step();
        lineStart = 1'b1;
        step();
        lineStart   = 1'b0;
        pixelEnable = 1'b0;
        checks++;
        if ({pixelValid, bitmapReady, pixelOut, wordDone, underflow} !== 5'b01000) begin
            errors++;
            $display("FAIL ls_flush got pv/rdy/po/wd/uf %b exp 01000",
                     {pixelValid, bitmapReady, pixelOut, wordDone, underflow});
        end
        bitmapIn    = 16'hC000;
        bitmapValid = 1'b1;
        step();
        bitmapValid = 1'b0;
        step();
        pixelEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pixelValid, pixelOut} !== {1'b1, (i < 2) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL ls_next_pix%0d got pv/po %b exp %b", i,
                         {pixelValid, pixelOut}, {1'b1, (i < 2) ? 1'b1 : 1'b0});
            end
            step();
        end
        flush_line();
    endtask

    task automatic test_async_reset();
        bitmapIn    = 16'hFFFF;
        bitmapValid = 1'b1;
        step();
        bitmapIn = 16'h0F0F;
        step();
        pixelEnable = 1'b1;
        step();
        bitmapValid = 1'b0;
        step();
        checks++;
        if ({pixelValid, bitmapReady, pixelOut} !== 3'b101) begin
            errors++;
            $display("FAIL arst_pre got pv/rdy/po %b exp 101", {pixelValid, bitmapReady, pixelOut});
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bitmapReady, pixelOut, pixelValid, wordDone, underflow} !== 5'b10000) begin
            errors++;
            $display("FAIL arst_immediate got %b exp 10000",
                     {bitmapReady, pixelOut, pixelValid, wordDone, underflow});
        end
        pixelEnable = 1'b0;
        #2;
        rst = 1'b0;
        step();
        checks++;
        if ({bitmapReady, pixelOut, pixelValid, wordDone, underflow} !== 5'b10000) begin
            errors++;
            $display("FAIL arst_release got %b exp 10000",
                     {bitmapReady, pixelOut, pixelValid, wordDone, underflow});
        end
        bitmapIn    = 16'hA000;
        bitmapValid = 1'b1;
        step();
        bitmapValid = 1'b0;
        step();
        pixelEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pixelValid, pixelOut} !== {1'b1, (i != 1) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL arst_word_pix%0d got pv/po %b exp %b", i,
                         {pixelValid, pixelOut}, {1'b1, (i != 1) ? 1'b1 : 1'b0});
            end
            step();
        end
        flush_line();
    endtask

    task automatic test_random();
        bit       q[$];
        bit       exp_bit;
        bit       m_hfull, m_sfull, m_wd, m_uf;
        int       m_cnt;
        bit       acc, cons, last, rel, src_hold;
        int       dut_uf, model_uf;
        m_hfull  = 1'b0;
        m_sfull  = 1'b0;
        m_wd     = 1'b0;
        m_uf     = 1'b0;
        m_cnt    = 0;
        src_hold = 1'b0;
        dut_uf   = 0;
        model_uf = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!src_hold) begin
                bitmapValid = 1'($urandom_range(0, 1));
                bitmapIn    = 16'($urandom);
            end
            pixelEnable = ($urandom_range(0, 3) != 0);
            checks++;
            if ({pixelValid, bitmapReady, wordDone, underflow} !== {m_sfull, ~m_hfull, m_wd, m_uf}) begin
                errors++;
                $display("FAIL rand_state cyc %0d got pv/rdy/wd/uf %b exp %b", cyc,
                         {pixelValid, bitmapReady, wordDone, underflow}, {m_sfull, ~m_hfull, m_wd, m_uf});
            end
            dut_uf   += int'(underflow);
            model_uf += int'(m_uf);
            acc  = bitmapValid & ~m_hfull;
            cons = pixelEnable & m_sfull;
            last = cons && (m_cnt == 15);
            rel  = m_hfull && (!m_sfull || last);
            if (cons) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_stream cyc %0d got pixel %b exp none pending", cyc, pixelOut);
                end else begin
                    exp_bit = q.pop_front();
                    if (pixelOut !== exp_bit) begin
                        errors++;
                        $display("FAIL rand_stream cyc %0d got %b exp %b", cyc, pixelOut, exp_bit);
                    end
                end
            end
            if (acc) begin
                for (int b = 15; b >= 0; b--) q.push_back(bitmapIn[b]);
            end
            src_hold = bitmapValid & ~acc;
            m_wd = last;
            m_uf = pixelEnable & ~m_sfull;
            if (rel) begin
                m_sfull = 1'b1;
                m_cnt   = 0;
            end else if (cons) begin
                if (last) begin
                    m_sfull = 1'b0;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (acc)      m_hfull = 1'b1;
            else if (rel) m_hfull = 1'b0;
            step();
        end
        checks++;
        if (dut_uf != model_uf) begin
            errors++;
            $display("FAIL rand_uflow_count got %0d exp %0d", dut_uf, model_uf);
        end
        flush_line();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underflow();
        test_line_start();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
